// File: rtl/wb_pipe_stage.sv
// Memory-to-writeback pipeline stage: two-entry elastic buffer (main + skid)
// with flush and a same-cycle forwarding port on the main entry.
module wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              link_in,
  input  logic              wb_en_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              link_out,
  output logic              wb_en_out,
  input  logic [RD_W-1:0]   fwd_rd,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_reg, state_next;

  logic [DATA_W-1:0] main_data_reg;
  logic [RD_W-1:0]   main_rd_reg;
  logic              main_link_reg;
  logic              main_wb_en_reg;
  logic              main_valid_reg, main_valid_next;

  logic [DATA_W-1:0] skid_data_reg;
  logic [RD_W-1:0]   skid_rd_reg;
  logic              skid_link_reg;
  logic              skid_wb_en_reg;
  logic              skid_valid_reg, skid_valid_next;

  logic              accept;
  logic              consume;
  logic              load_main_from_in;
  logic              load_main_from_skid;
  logic              load_skid;

  // in_ready comes straight from a flop so it never sees out_ready combinationally
  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & in_ready;
  assign consume  = main_valid_reg & out_ready;

  always_comb begin
    state_next          = state_reg;
    main_valid_next     = main_valid_reg;
    skid_valid_next     = skid_valid_reg;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    if (flush) begin
      state_next      = ST_EMPTY;
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            load_main_from_in = 1'b1;
            main_valid_next   = 1'b1;
            state_next        = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            load_main_from_in = 1'b1;
          end else if (accept) begin
            load_skid       = 1'b1;
            skid_valid_next = 1'b1;
            state_next      = ST_TWO;
          end else if (consume) begin
            main_valid_next = 1'b0;
            state_next      = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            load_main_from_skid = 1'b1;
            skid_valid_next     = 1'b0;
            state_next          = ST_ONE;
          end
        end
        default: begin
          state_next      = ST_EMPTY;
          main_valid_next = 1'b0;
          skid_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_EMPTY;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  // Payload is left stale on flush; the cleared valids mask it everywhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_reg  <= '0;
      main_rd_reg    <= '0;
      main_link_reg  <= 1'b0;
      main_wb_en_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_rd_reg    <= '0;
      skid_link_reg  <= 1'b0;
      skid_wb_en_reg <= 1'b0;
    end else begin
      if (load_main_from_in) begin
        main_data_reg  <= data_in;
        main_rd_reg    <= rd_in;
        main_link_reg  <= link_in;
        main_wb_en_reg <= wb_en_in;
      end else if (load_main_from_skid) begin
        main_data_reg  <= skid_data_reg;
        main_rd_reg    <= skid_rd_reg;
        main_link_reg  <= skid_link_reg;
        main_wb_en_reg <= skid_wb_en_reg;
      end
      if (load_skid) begin
        skid_data_reg  <= data_in;
        skid_rd_reg    <= rd_in;
        skid_link_reg  <= link_in;
        skid_wb_en_reg <= wb_en_in;
      end
    end
  end

  assign out_valid = main_valid_reg;
  assign data_out  = main_data_reg;
  assign rd_out    = main_rd_reg;
  assign link_out  = main_link_reg;
  assign wb_en_out = main_wb_en_reg & main_valid_reg;

  // Forwarding looks only at the main entry; a beat in skid stalls upstream instead.
  logic [RD_W-1:0] rd_match_bits;
  for (genvar gi = 0; gi < RD_W; gi++) begin : g_rd_match
    assign rd_match_bits[gi] = ~(main_rd_reg[gi] ^ fwd_rd[gi]);
  end

  assign fwd_hit  = main_valid_reg & main_wb_en_reg & (&rd_match_bits);
  assign fwd_data = main_data_reg;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage: scoreboard-ordered beats, backpressure,
// flush, forwarding, reset mid-operation and a 64-bit/5-bit instance.
module tb_wb_pipe_stage;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rd;
    logic        link;
    logic        wb_en;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] data_in;
  logic [3:0]  rd_in;
  logic        link_in, wb_en_in, flush;
  logic        out_valid, out_ready;
  logic [31:0] data_out;
  logic [3:0]  rd_out;
  logic        link_out, wb_en_out;
  logic [3:0]  fwd_rd;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  logic        w_in_valid, w_in_ready;
  logic [63:0] w_data_in;
  logic [4:0]  w_rd_in;
  logic        w_link_in, w_wb_en_in, w_flush;
  logic        w_out_valid, w_out_ready;
  logic [63:0] w_data_out;
  logic [4:0]  w_rd_out;
  logic        w_link_out, w_wb_en_out;
  logic [4:0]  w_fwd_rd;
  logic        w_fwd_hit;
  logic [63:0] w_fwd_data;

  int checks = 0;
  int errors = 0;
  beat_t sb[$];

  wb_pipe_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .rd_in(rd_in), .link_in(link_in), .wb_en_in(wb_en_in),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .rd_out(rd_out), .link_out(link_out), .wb_en_out(wb_en_out),
    .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  wb_pipe_stage #(.DATA_W(64), .RD_W(5)) dut_w (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .data_in(w_data_in), .rd_in(w_rd_in), .link_in(w_link_in), .wb_en_in(w_wb_en_in),
    .flush(w_flush),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .data_out(w_data_out), .rd_out(w_rd_out), .link_out(w_link_out), .wb_en_out(w_wb_en_out),
    .fwd_rd(w_fwd_rd), .fwd_hit(w_fwd_hit), .fwd_data(w_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] d, input logic [3:0] r,
                       input logic l, input logic w);
    in_valid = v;
    data_in  = d;
    rd_in    = r;
    link_in  = l;
    wb_en_in = w;
  endtask

  // One clock: compare outputs against the model, then advance the model over the edge.
  task automatic step(input string tag);
    logic exp_valid, exp_ready, acc, con;
    beat_t b;
    exp_valid = (sb.size() != 0);
    exp_ready = (sb.size() < 2);
    check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
    check({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, exp_ready});
    if (exp_valid) begin
      b = sb[0];
      check({tag, ".data_out"}, {32'd0, data_out}, {32'd0, b.data});
      check({tag, ".rd_out"}, {60'd0, rd_out}, {60'd0, b.rd});
      check({tag, ".link_out"}, {63'd0, link_out}, {63'd0, b.link});
      check({tag, ".wb_en_out"}, {63'd0, wb_en_out}, {63'd0, b.wb_en});
      if (out_ready)
        $display("beat out %s: data=%h rd=%0d link=%0b wb_en=%0b", tag, data_out, rd_out, link_out, wb_en_out);
    end else begin
      check({tag, ".wb_en_out_idle"}, {63'd0, wb_en_out}, 64'd0);
    end
    acc = in_valid && exp_ready;
    con = exp_valid && out_ready;
    b.data = data_in; b.rd = rd_in; b.link = link_in; b.wb_en = wb_en_in;
    @(posedge clk);
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (con) void'(sb.pop_front());
      if (acc) sb.push_back(b);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; fwd_rd = '0;
    offer(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
    w_in_valid = 1'b0; w_data_in = '0; w_rd_in = '0; w_link_in = 1'b0;
    w_wb_en_in = 1'b0; w_flush = 1'b0; w_out_ready = 1'b0; w_fwd_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.in_ready", {63'd0, in_ready}, 64'd1);
    check("rst.data_out", {32'd0, data_out}, 64'd0);
    check("rst.rd_out", {60'd0, rd_out}, 64'd0);
    check("rst.link_out", {63'd0, link_out}, 64'd0);
    check("rst.wb_en_out", {63'd0, wb_en_out}, 64'd0);
    check("rst.fwd_hit", {63'd0, fwd_hit}, 64'd0);
    reset = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1;
    offer(1'b1, 32'h11111111, 4'd1, 1'b0, 1'b1); step("stream0");
    offer(1'b1, 32'h22222222, 4'd2, 1'b1, 1'b1); step("stream1");
    offer(1'b1, 32'h33333333, 4'd3, 1'b0, 1'b0); step("stream2");
    offer(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
    check("stream.no_bubble", {63'd0, out_valid}, 64'd1);
    step("stream3");
    step("stream4");

    // Backpressure: A held, B in skid, C refused
    out_ready = 1'b0;
    offer(1'b1, 32'hAAAA0000, 4'd7, 1'b1, 1'b1); step("bp_a");
    offer(1'b1, 32'hBBBB0000, 4'd8, 1'b0, 1'b1); step("bp_b");
    offer(1'b1, 32'hCCCC0000, 4'd9, 1'b0, 1'b1); step("bp_c_refused");
    step("bp_hold");
    offer(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step("bp_drain_a");
    step("bp_drain_b");
    step("bp_empty");

    // Flush in TWO with a beat offered
    out_ready = 1'b0;
    offer(1'b1, 32'h44440001, 4'd4, 1'b0, 1'b1); step("fl_fill0");
    offer(1'b1, 32'h44440002, 4'd5, 1'b0, 1'b1); step("fl_fill1");
    offer(1'b1, 32'h44440003, 4'd6, 1'b0, 1'b1);
    flush = 1'b1;
    step("fl_flush");
    flush = 1'b0;
    offer(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
    check("fl.out_valid", {63'd0, out_valid}, 64'd0);
    check("fl.in_ready", {63'd0, in_ready}, 64'd1);
    check("fl.wb_en_out", {63'd0, wb_en_out}, 64'd0);
    out_ready = 1'b1;
    step("fl_after0");
    step("fl_after1");

    // Forwarding from the main entry
    out_ready = 1'b0;
    offer(1'b1, 32'hDEADBEEF, 4'd5, 1'b0, 1'b1); step("fwd_load");
    offer(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
    fwd_rd = 4'd5; #1;
    check("fwd.hit_rd5", {63'd0, fwd_hit}, 64'd1);
    check("fwd.data_rd5", {32'd0, fwd_data}, 64'hDEADBEEF);
    fwd_rd = 4'd6; #1;
    check("fwd.hit_rd6", {63'd0, fwd_hit}, 64'd0);
    out_ready = 1'b1;
    step("fwd_drain0");
    out_ready = 1'b0;
    offer(1'b1, 32'hDEADBEEF, 4'd5, 1'b0, 1'b0); step("fwd_load_nowb");
    offer(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
    fwd_rd = 4'd5; #1;
    check("fwd.hit_nowb", {63'd0, fwd_hit}, 64'd0);
    out_ready = 1'b1;
    step("fwd_drain1");
    fwd_rd = 4'd0;

    // Reset in TWO together with flush and an offered beat
    out_ready = 1'b0;
    offer(1'b1, 32'h55550001, 4'd11, 1'b1, 1'b1); step("rm_fill0");
    offer(1'b1, 32'h55550002, 4'd12, 1'b1, 1'b1); step("rm_fill1");
    offer(1'b1, 32'h55550003, 4'd13, 1'b1, 1'b1);
    reset = 1'b1; flush = 1'b1;
    step("rm_reset");
    reset = 1'b0; flush = 1'b0;
    offer(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
    check("rm.out_valid", {63'd0, out_valid}, 64'd0);
    check("rm.in_ready", {63'd0, in_ready}, 64'd1);
    check("rm.data_out", {32'd0, data_out}, 64'd0);
    check("rm.rd_out", {60'd0, rd_out}, 64'd0);
    check("rm.link_out", {63'd0, link_out}, 64'd0);
    check("rm.wb_en_out", {63'd0, wb_en_out}, 64'd0);
    check("rm.fwd_hit", {63'd0, fwd_hit}, 64'd0);
    out_ready = 1'b1;
    offer(1'b1, 32'h66666666, 4'd14, 1'b1, 1'b1); step("rm_first");
    offer(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4 && sb.size() != 0; i++) step("rm_drain");
    check("rm.drained", {63'd0, (sb.size() == 0)}, 64'd1);

    // 64-bit data, 5-bit register index
    w_in_valid = 1'b1; w_data_in = 64'hFFFF_0000_1234_5678; w_rd_in = 5'd31;
    w_link_in = 1'b0; w_wb_en_in = 1'b1;
    @(posedge clk); @(negedge clk);
    w_in_valid = 1'b0;
    w_fwd_rd = 5'd31; #1;
    check("wide.out_valid", {63'd0, w_out_valid}, 64'd1);
    check("wide.data_out", w_data_out, 64'hFFFF_0000_1234_5678);
    check("wide.rd_out", {59'd0, w_rd_out}, 64'd31);
    check("wide.fwd_hit", {63'd0, w_fwd_hit}, 64'd1);
    check("wide.fwd_data", w_fwd_data, 64'hFFFF_0000_1234_5678);
    $display("beat out wide: data=%h rd=%0d", w_data_out, w_rd_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
